// File: rtl/shift_sequencer.sv
// Four-state serial shift controller: rotates a parallel word out LSB-first (TX)
// or captures a serial stream MSB-in (RX), with abort and a one-cycle done pulse.
module shift_sequencer #(
    parameter  int NBITS_DATA = 4,
    localparam int CNT_W      = (NBITS_DATA > 1) ? $clog2(NBITS_DATA) : 1
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  mode,
    input  logic [NBITS_DATA-1:0] par_in,
    input  logic                  ser_in,
    output logic                  ser_out,
    output logic [NBITS_DATA-1:0] par_out,
    output logic                  busy,
    output logic                  done,
    output logic                  load_en,
    output logic                  shift_en,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      bit_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS_DATA - 1);

    state_t                  state_q, state_d;
    logic [NBITS_DATA-1:0]   data_q,  data_d;
    logic [NBITS_DATA-1:0]   par_q,   par_d;
    logic [CNT_W-1:0]        cnt_q,   cnt_d;
    logic                    mode_q,  mode_d;
    logic                    new_bit;
    logic [NBITS_DATA-1:0]   shifted;

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            par_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            par_q   <= par_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // TX rotates the outgoing LSB back into the MSB; RX feeds ser_in into the MSB.
    assign new_bit = mode_q ? ser_in : data_q[0];
    assign shifted = {new_bit, data_q[NBITS_DATA-1:1]};

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        par_d   = par_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    data_d  = mode ? '0 : par_in;
                    mode_d  = mode;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    data_d = shifted;
                    if (cnt_q == LAST_CNT) begin
                        par_d   = shifted;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ser_out  = data_q[0];
    assign par_out  = par_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign load_en  = (state_q == LOAD);
    assign shift_en = (state_q == SHIFT);
    assign state    = state_q;
    assign bit_cnt  = cnt_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: TX, RX, abort, back-to-back start,
// asynchronous reset mid-transfer, and mode/start changes during a transfer.
module tb_shift_sequencer;

    logic       clk_2;
    logic       reset;
    logic       start;
    logic       abort;
    logic       mode;
    logic [3:0] par_in;
    logic       ser_in;
    logic       ser_out;
    logic [3:0] par_out;
    logic       busy;
    logic       done;
    logic       load_en;
    logic       shift_en;
    logic [1:0] state;
    logic [1:0] bit_cnt;

    int unsigned n_checks;
    int unsigned n_fail;

    shift_sequencer #(.NBITS_DATA(4)) dut (
        .clk_2    (clk_2),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .mode     (mode),
        .par_in   (par_in),
        .ser_in   (ser_in),
        .ser_out  (ser_out),
        .par_out  (par_out),
        .busy     (busy),
        .done     (done),
        .load_en  (load_en),
        .shift_en (shift_en),
        .state    (state),
        .bit_cnt  (bit_cnt)
    );

    initial begin
        clk_2 = 1'b0;
        forever #5 clk_2 = ~clk_2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_2);
        @(negedge clk_2);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"},   32'(state),    32'd0);
        check({tag, "_busy"},    32'(busy),     32'd0);
        check({tag, "_done"},    32'(done),     32'd0);
        check({tag, "_load"},    32'(load_en),  32'd0);
        check({tag, "_shift"},   32'(shift_en), 32'd0);
        check({tag, "_serout"},  32'(ser_out),  32'd0);
        check({tag, "_parout"},  32'(par_out),  32'd0);
        check({tag, "_bitcnt"},  32'(bit_cnt),  32'd0);
    endtask

    logic [3:0] tx_word;
    logic [3:0] rx_bits;
    int unsigned done_count;
    logic [1:0] exp_state;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset  = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        mode   = 1'b0;
        par_in = 4'b0000;
        ser_in = 1'b0;

        // Reset state
        @(negedge clk_2);
        check_all_zero("rst");
        reset = 1'b0;
        tick();
        check("idle_after_rst", 32'(state), 32'd0);

        // TX 1011; mode and start disturbed while the transfer runs
        tx_word = 4'b1011;
        mode    = 1'b0;
        par_in  = tx_word;
        start   = 1'b1;
        tick();
        check("tx_load_state", 32'(state),   32'd1);
        check("tx_load_en",    32'(load_en), 32'd1);
        check("tx_load_busy",  32'(busy),    32'd1);
        start = 1'b0;
        tick();
        mode  = 1'b1;
        start = 1'b1;
        par_in = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("tx_serout%0d", k), 32'(ser_out),  32'(tx_word[k]));
            check($sformatf("tx_shen%0d", k),   32'(shift_en), 32'd1);
            check($sformatf("tx_cnt%0d", k),    32'(bit_cnt),  32'(k));
            check($sformatf("tx_nodone%0d", k), 32'(done),     32'd0);
            tick();
        end
        check("tx_done",     32'(done),    32'd1);
        check("tx_done_st",  32'(state),   32'd3);
        check("tx_parout",   32'(par_out), 32'hB);
        check("tx_cnt_rst",  32'(bit_cnt), 32'd0);
        tick();
        check("tx_back_idle", 32'(state), 32'd0);
        check("tx_done_1cyc", 32'(done),  32'd0);
        start = 1'b0;
        mode  = 1'b0;
        tick();
        check("tx_no_queued", 32'(state), 32'd0);

        // RX: serial 1,0,1,1 -> 4'b1101
        rx_bits = 4'b1101;
        mode    = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("rx_cleared", 32'(ser_out), 32'd0);
        mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rx_nodone%0d", k), 32'(done), 32'd0);
            ser_in = rx_bits[k];
            tick();
        end
        ser_in = 1'b0;
        check("rx_done",   32'(done),    32'd1);
        check("rx_parout", 32'(par_out), 32'hD);
        tick();
        check("rx_idle",   32'(state),   32'd0);

        // Abort on the 2nd SHIFT edge
        mode   = 1'b0;
        par_in = 4'b0110;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("ab_pre_cnt", 32'(bit_cnt), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_state",  32'(state),   32'd0);
        check("ab_busy",   32'(busy),    32'd0);
        check("ab_cnt",    32'(bit_cnt), 32'd0);
        check("ab_parout", 32'(par_out), 32'hD);
        check("ab_hold",   32'(ser_out), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("ab_nodone%0d", k), 32'(done), 32'd0);
            tick();
        end

        // Abort in LOAD leaves data_reg untouched
        par_in = 4'b0110;
        start  = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abl_state", 32'(state),   32'd0);
        check("abl_hold",  32'(ser_out), 32'd1);

        // start held high: period N+3 = 7
        par_in     = 4'b1001;
        mode       = 1'b0;
        start      = 1'b1;
        done_count = 0;
        for (int e = 0; e < 21; e++) begin
            tick();
            case (e % 7)
                0:       exp_state = 2'd1;
                5:       exp_state = 2'd3;
                6:       exp_state = 2'd0;
                default: exp_state = 2'd2;
            endcase
            check($sformatf("bb_state%0d", e), 32'(state), 32'(exp_state));
            check($sformatf("bb_done%0d", e),  32'(done),  32'((e % 7) == 5));
            if (done) done_count++;
        end
        start = 1'b0;
        check("bb_done_count", done_count, 32'd3);
        check("bb_parout", 32'(par_out), 32'h9);
        tick();
        check("bb_idle", 32'(state), 32'd0);

        // Asynchronous reset mid-SHIFT
        par_in = 4'b1111;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("ar_pre_state", 32'(state), 32'd2);
        #2 reset = 1'b1;
        #1 check_all_zero("ar");
        @(negedge clk_2);
        reset = 1'b0;
        tick();
        check("ar_stay_idle", 32'(state), 32'd0);
        check("ar_no_done",   32'(done),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter NBITS_DATA, default 4: width of the parallel word and the number of shifts per transfer.
REQ-002 clk_2  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  transfer request, sampled only in IDLE.
REQ-005 abort  input  1  cancels a transfer in LOAD or SHIFT.
REQ-006 mode  input  1  0 = TX (rotate parallel word out serially), 1 = RX (capture serial stream).
REQ-007 par_in  input  NBITS_DATA  word loaded in TX mode.
REQ-008 ser_in  input  1  serial data, sampled in RX mode.
REQ-009 ser_out  output  1  serial data, always equal to data_reg[0].
REQ-010 par_out  output  NBITS_DATA  last completed word, registered.
REQ-011 busy  output  1  high in LOAD, SHIFT and DONE.
REQ-012 done  output  1  one-cycle completion pulse, high only in DONE.
REQ-013 load_en, shift_en  output  1 each  high in LOAD and SHIFT respectively (datapath strobes).
REQ-014 state  output  2  IDLE=0, LOAD=1, SHIFT=2, DONE=3.
REQ-015 bit_cnt  output  clog2(NBITS_DATA)  number of shifts completed in the current transfer.

Function
REQ-016 Internal register data_reg, NBITS_DATA bits; each shift moves bit i+1 into bit i and the new bit into the MSB (MSB-in, LSB-out).
REQ-017 IDLE: start=1 at an edge moves to LOAD; otherwise stay; data_reg and par_out hold.
REQ-018 LOAD (exactly 1 cycle): at the exit edge, data_reg <= par_in (TX) or all zeros (RX), bit_cnt <= 0, and the state moves to SHIFT.
REQ-019 mode is sampled only at the LOAD exit edge and is held internally for the rest of the transfer; later changes to mode are ignored.
REQ-020 SHIFT: one shift per edge; the new MSB is data_reg[0] in TX (rotate) or ser_in in RX; bit_cnt increments.
REQ-021 SHIFT, edge with bit_cnt = NBITS_DATA-1: perform the final shift, load par_out with the shifted value, move to DONE and reset bit_cnt to 0.
REQ-022 DONE (exactly 1 cycle): done=1; next edge returns to IDLE; start is ignored in DONE.
REQ-023 Latency (N = NBITS_DATA): start sampled at edge 0, LOAD at edge 1, shifts at edges 2..N+1, done high from edge N+1 to edge N+2, and a new start is accepted no earlier than edge N+2.
REQ-024 TX: ser_out presents par_in[0], par_in[1], ... during successive SHIFT cycles (LSB first); par_out at DONE equals par_in as loaded.
REQ-025 RX: the first sampled ser_in bit ends in par_out[0] and the last in par_out[N-1].
REQ-026 start held high continuously: each transfer completes, then one IDLE cycle precedes the next LOAD.
REQ-027 abort=1 at an edge in LOAD or SHIFT: go to IDLE, bit_cnt <= 0, no done pulse, par_out unchanged, data_reg holds.
REQ-028 abort has priority over shifting in the same cycle; abort in IDLE or DONE has no effect.
REQ-029 start asserted while busy has no effect and is not queued.

Reset
REQ-030 While reset=1, the block is asynchronously forced to: state=IDLE, data_reg=0, par_out=0, bit_cnt=0, busy=0, done=0, load_en=0, shift_en=0, ser_out=0.
REQ-031 Reset asserted mid-transfer aborts it immediately with no done pulse; operation resumes at the first clk_2 edge after reset falls.

Verification
REQ-032 TX: N=4, mode=0, par_in=4'b1011, start pulse -> ser_out = 1,1,0,1 over 4 SHIFT cycles; done one cycle; par_out=4'b1011.
REQ-033 RX: mode=1, ser_in = 1,0,1,1 on the 4 SHIFT edges -> par_out=4'b1101 with done; total start-to-done = 5 edges.
REQ-034 abort=1 on the 2nd SHIFT edge -> IDLE next cycle, no done, par_out keeps its previous value (4'b1101).
REQ-035 start held high for 20 cycles -> transfers repeat every N+3 = 7 cycles; done pulses exactly once per transfer.
REQ-036 reset pulsed mid-SHIFT (asynchronously, between edges) -> all outputs read 0 before the next edge; state=IDLE.
REQ-037 mode toggled during SHIFT and start pulsed during SHIFT/DONE -> no effect on the running transfer and no extra transfer.
